change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 132 +++++++++++++
 tb/tb_change_dispenser.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// Coin change dispenser: pays an amount in 5-cent units as timed dime/nickel
// ejector pulses, preferring dimes and falling back to nickels when the dime tube is empty.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       change_valid,
    input  logic [2:0] change,
    input  logic       dime_empty,
    input  logic       nickel_empty,
    input  logic       fault_clr,
    output logic       dime_eject,
    output logic       nickel_eject,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] remaining
);

    // state | meaning
    // IDLE  | waiting for a change strobe
    // PICK  | one cycle: choose next coin from remaining and tube status
    // PULSE | selected ejector held high for PULSE_CYCLES
    // GAP   | both ejectors low for GAP_CYCLES
    // DONE  | one-cycle done pulse
    // FAULT | no coin can be paid; wait for fault_clr
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PICK  = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    localparam logic [3:0] PULSE_LOAD = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [2:0] rem, rem_n;
    logic       sel_dime, sel_dime_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            rem      <= 3'd0;
            sel_dime <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            sel_dime <= sel_dime_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        rem_n      = rem;
        sel_dime_n = sel_dime;
        case (state)
            IDLE: begin
                if (change_valid) begin
                    if (change != 3'd0) begin
                        rem_n   = change;
                        state_n = PICK;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            PICK: begin
                if (rem == 3'd0) begin
                    state_n = DONE;
                end else if (rem >= 3'd2 && !dime_empty) begin
                    sel_dime_n = 1'b1;
                    cnt_n      = PULSE_LOAD;
                    state_n    = PULSE;
                end else if (!nickel_empty) begin
                    sel_dime_n = 1'b0;
                    cnt_n      = PULSE_LOAD;
                    state_n    = PULSE;
                end else begin
                    state_n = FAULT;
                end
            end
            PULSE: begin
                if (cnt == 4'd0) begin
                    // saturating subtract keeps remaining from wrapping
                    if (sel_dime)
                        rem_n = (rem >= 3'd2) ? rem - 3'd2 : 3'd0;
                    else
                        rem_n = (rem >= 3'd1) ? rem - 3'd1 : 3'd0;
                    cnt_n   = GAP_LOAD;
                    state_n = GAP;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            GAP: begin
                if (cnt == 4'd0)
                    state_n = PICK;
                else
                    cnt_n = cnt - 4'd1;
            end
            DONE: begin
                state_n = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    rem_n   = 3'd0;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign dime_eject   = (state == PULSE) &&  sel_dime;
    assign nickel_eject = (state == PULSE) && !sel_dime;
    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign fault        = (state == FAULT);
    assign remaining    = rem;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: a coin-timeline model predicts every
// output cycle by cycle for directed and randomized payouts.
module tb_change_dispenser;

    localparam int P = 4;
    localparam int G = 2;
    localparam int N = 160;

    logic       clk = 1'b0;
    logic       rst, change_valid, dime_empty, nickel_empty, fault_clr;
    logic [2:0] change;
    logic       dime_eject, nickel_eject, busy, done, fault;
    logic [2:0] remaining;

    change_dispenser #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst(rst), .change_valid(change_valid), .change(change),
        .dime_empty(dime_empty), .nickel_empty(nickel_empty), .fault_clr(fault_clr),
        .dime_eject(dime_eject), .nickel_eject(nickel_eject), .busy(busy),
        .done(done), .fault(fault), .remaining(remaining)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cur_cyc = 0;

    logic [2:0] e_rem [N];
    logic       e_de [N], e_ne [N], e_busy [N], e_done [N], e_fault [N];
    logic       de_in [N], ne_in [N];
    int         n_cyc, clr_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s cyc=%0d got=%0d want=%0d", tag, cur_cyc, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Coin timeline: a pick cycle, then P eject cycles, then G gap cycles per coin.
    task automatic model(input int chg);
        int t, rem, coin;
        for (int i = 0; i < N; i++) begin
            e_rem[i] = 3'd0; e_de[i] = 1'b0; e_ne[i] = 1'b0;
            e_busy[i] = 1'b0; e_done[i] = 1'b0; e_fault[i] = 1'b0;
        end
        clr_at = -1;
        rem = chg;
        t = 1;
        if (chg == 0) begin
            e_busy[1] = 1'b1; e_done[1] = 1'b1;
            n_cyc = 3;
            return;
        end
        while (1) begin
            e_busy[t] = 1'b1;
            e_rem[t]  = 3'(rem);
            if (rem == 0) begin
                e_busy[t+1] = 1'b1; e_done[t+1] = 1'b1;
                n_cyc = t + 3;
                break;
            end else if (rem >= 2 && !de_in[t]) begin
                coin = 2;
            end else if (!ne_in[t]) begin
                coin = 1;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    e_busy[t+k] = 1'b1; e_fault[t+k] = 1'b1; e_rem[t+k] = 3'(rem);
                end
                clr_at = t + 4;
                n_cyc  = t + 7;
                break;
            end
            for (int k = 1; k <= P; k++) begin
                e_busy[t+k] = 1'b1; e_rem[t+k] = 3'(rem);
                if (coin == 2) e_de[t+k] = 1'b1; else e_ne[t+k] = 1'b1;
            end
            rem = rem - coin;
            for (int k = P + 1; k <= P + G; k++) begin
                e_busy[t+k] = 1'b1; e_rem[t+k] = 3'(rem);
            end
            t = t + P + G + 1;
        end
    endtask

    task automatic set_tubes(input bit de, input bit ne, input bit rnd);
        for (int i = 0; i < N; i++) begin
            de_in[i] = rnd ? ($urandom_range(0, 3) == 0) : de;
            ne_in[i] = rnd ? ($urandom_range(0, 4) == 0) : ne;
        end
    endtask

    task automatic run_txn(input int chg, input bit extras, input int force_c, input int force_chg);
        int last_busy;
        model(chg);
        last_busy = 0;
        for (int i = 0; i < n_cyc; i++) if (e_busy[i]) last_busy = i;
        for (int c = 0; c < n_cyc; c++) begin
            cur_cyc = c;
            change_valid = 1'b0;
            change       = 3'($urandom_range(0, 7));
            fault_clr    = 1'b0;
            if (c == 0) begin
                change_valid = 1'b1;
                change       = 3'(chg);
            end else if (c == force_c) begin
                change_valid = 1'b1;
                change       = 3'(force_chg);
            end else if (extras && c <= last_busy) begin
                change_valid = ($urandom_range(0, 2) == 0);
            end
            if (c == clr_at)
                fault_clr = 1'b1;
            else if (extras && !e_fault[c])
                fault_clr = ($urandom_range(0, 3) == 0);
            dime_empty   = de_in[c];
            nickel_empty = ne_in[c];
            chk("dime_eject",   32'(dime_eject),   32'(e_de[c]));
            chk("nickel_eject", 32'(nickel_eject), 32'(e_ne[c]));
            chk("busy",         32'(busy),         32'(e_busy[c]));
            chk("done",         32'(done),         32'(e_done[c]));
            chk("fault",        32'(fault),        32'(e_fault[c]));
            chk("remaining",    32'(remaining),    32'(e_rem[c]));
            tick();
        end
        change_valid = 1'b0;
        fault_clr    = 1'b0;
    endtask

    initial begin
        rst = 1'b1; change_valid = 1'b1; change = 3'd5;
        dime_empty = 1'b0; nickel_empty = 1'b0; fault_clr = 1'b1;
        tick();
        tick();
        chk("rst_busy",      32'(busy),         32'd0);
        chk("rst_done",      32'(done),         32'd0);
        chk("rst_fault",     32'(fault),        32'd0);
        chk("rst_dime",      32'(dime_eject),   32'd0);
        chk("rst_nickel",    32'(nickel_eject), 32'd0);
        chk("rst_remaining", 32'(remaining),    32'd0);
        rst = 1'b0; change_valid = 1'b0; fault_clr = 1'b0;
        tick();

        set_tubes(1'b0, 1'b0, 1'b0); run_txn(3, 1'b0, -1, 0);  // dime then nickel, done at 16
        set_tubes(1'b1, 1'b0, 1'b0); run_txn(4, 1'b0, -1, 0);  // four nickels
        set_tubes(1'b0, 1'b0, 1'b0); run_txn(0, 1'b0, -1, 0);  // immediate done
        set_tubes(1'b1, 1'b1, 1'b0); run_txn(2, 1'b0, -1, 0);  // fault at cycle 2, then clear
        set_tubes(1'b0, 1'b0, 1'b0); run_txn(7, 1'b0, 3, 1);   // strobe during pulse ignored
        set_tubes(1'b0, 1'b1, 1'b0); run_txn(5, 1'b1, -1, 0);  // odd amount, no nickels -> fault

        for (int r = 0; r < 40; r++) begin
            set_tubes(1'b0, 1'b0, ($urandom_range(0, 1) == 1));
            run_txn(int'($urandom_range(0, 7)), 1'b1, -1, 0);
        end

        // reset in the second cycle of a dime pulse
        cur_cyc = 0;
        dime_empty = 1'b0; nickel_empty = 1'b0;
        change_valid = 1'b1; change = 3'd2;
        tick();
        change_valid = 1'b0;
        tick();
        tick();
        tick();
        cur_cyc = 3;
        chk("pre_rst_dime", 32'(dime_eject), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_cyc = 4;
        chk("midrst_dime",      32'(dime_eject), 32'd0);
        chk("midrst_busy",      32'(busy),       32'd0);
        chk("midrst_remaining", 32'(remaining),  32'd0);
        for (int k = 0; k < 8; k++) begin
            cur_cyc = 5 + k;
            chk("post_rst_done",  32'(done),  32'd0);
            chk("post_rst_fault", 32'(fault), 32'd0);
            chk("post_rst_busy",  32'(busy),  32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
